// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the IF stage: control-transfer classes, reset PC and
// the branch-offset helper used by the next-PC selector.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_J    = 3'd3,
    BR_JAL  = 3'd4,
    BR_JR   = 3'd5
  } br_type_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  // Sign-extended 16-bit branch immediate scaled to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_npc.sv
// Combinational next-PC selection. Branch/jump targets are formed from the
// instruction currently in ID, so the delay slot is always fetched first.
module fetch_ctrl_npc
  import fetch_ctrl_pkg::*;
(
  input  logic [31:0] pc_f_i,
  input  logic [31:0] pc_d_i,
  input  logic [31:0] ir_d_i,
  input  logic [2:0]  br_type_i,
  input  logic        co_i,
  input  logic [31:0] rs_fwd_i,
  output logic [31:0] npc_o,
  output logic        misalign_o
);

  logic [31:0] seq_pc;
  logic [31:0] pc_d_plus4;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] jr_target;
  logic        unused_ir_hi;

  assign seq_pc       = pc_f_i + 32'd4;
  assign pc_d_plus4   = pc_d_i + 32'd4;
  assign br_target    = pc_d_plus4 + branch_offset(ir_d_i[15:0]);
  assign jmp_target   = {pc_d_plus4[31:28], ir_d_i[25:0], 2'b00};
  assign jr_target    = {rs_fwd_i[31:2], 2'b00};
  assign unused_ir_hi = ^ir_d_i[31:26];

  // Encodings 6 and 7 fall through to sequential fetch.
  always_comb begin
    npc_o      = seq_pc;
    misalign_o = 1'b0;
    case (br_type_i)
      BR_BEQ: begin
        if (co_i) npc_o = br_target;
      end
      BR_BNE: begin
        if (!co_i) npc_o = br_target;
      end
      BR_J, BR_JAL: begin
        npc_o = jmp_target;
      end
      BR_JR: begin
        npc_o      = jr_target;
        misalign_o = |rs_fwd_i[1:0];
      end
      default: begin
        npc_o = seq_pc;
      end
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF stage: PC register, IF/ID pipeline register and instruction-memory
// addressing for the five-stage MIPS core.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       br_type,
  input  logic             co,
  input  logic [31:0]      rs_fwd,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      pc_f,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      ir_d,
  output logic [31:0]      pc_d,
  output logic [31:0]      pc8_d,
  output logic             addr_err
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ir_d_q, ir_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] npc;
  logic        misalign;
  logic [31:0] pc_off;
  logic        unused_pc_off;

  fetch_ctrl_npc u_npc (
    .pc_f_i     (pc_f_q),
    .pc_d_i     (pc_d_q),
    .ir_d_i     (ir_d_q),
    .br_type_i  (br_type),
    .co_i       (co),
    .rs_fwd_i   (rs_fwd),
    .npc_o      (npc),
    .misalign_o (misalign)
  );

  // A stall holds everything and defers any redirect until release.
  always_comb begin
    pc_f_d     = pc_f_q;
    ir_d_d     = ir_d_q;
    pc_d_d     = pc_d_q;
    addr_err_d = 1'b0;
    if (!stall) begin
      pc_f_d     = npc;
      ir_d_d     = im_rdata;
      pc_d_d     = pc_f_q;
      addr_err_d = misalign;
    end
  end

  // IF -> ID boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q     <= RESET_PC;
      ir_d_q     <= NOP;
      pc_d_q     <= RESET_PC;
      addr_err_q <= 1'b0;
    end else begin
      pc_f_q     <= pc_f_d;
      ir_d_q     <= ir_d_d;
      pc_d_q     <= pc_d_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Memory is based at RESET_PC; addresses outside it wrap silently.
  assign pc_off        = pc_f_q - RESET_PC;
  assign im_addr       = pc_off[IM_AW+1:2];
  assign unused_pc_off = ^{pc_off[31:IM_AW+2], pc_off[1:0]};

  assign pc_f     = pc_f_q;
  assign ir_d     = ir_d_q;
  assign pc_d     = pc_d_q;
  assign pc8_d    = pc_d_q + 32'd8;
  assign addr_err = addr_err_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- IF-stage PC register, next-PC selection and IF/ID pipeline register for the five-stage MIPS core.
- Consumes the ID-stage equality flag from the branch comparator and the decoded branch/jump class.
- Redirects fetch with MIPS delay-slot semantics.
- Emits the instruction-memory word address, and the IR and PC values for the ID stage.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; also the base address of instruction memory.
- IM_AW, 10, instruction-memory word-address width (1024 words = 4 KiB).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  from hazard unit; freezes PC and IF/ID.
- br_type  in  3  ID-stage control-transfer class: 0 none, 1 beq, 2 bne, 3 j, 4 jal, 5 jr. Values 6–7 are treated as none.
- co  in  1  comparator equality flag for the instruction in ID (1 = operands equal).
- rs_fwd  in  32  forwarded rs value in ID, used as the jr target.
- im_rdata  in  32  instruction word read combinationally at im_addr.
- pc_f  out  32  current fetch PC.
- im_addr  out  IM_AW  equals (pc_f − RESET_PC)[IM_AW+1:2].
- ir_d  out  32  IF/ID instruction register.
- pc_d  out  32  IF/ID PC of ir_d.
- pc8_d  out  32  pc_d + 8, the jal link value.
- addr_err  out  1  one-cycle pulse: jr target not word-aligned.

Behaviour:
- Reset (async, immediate): pc_f = RESET_PC; ir_d = 0 (nop); pc_d = RESET_PC; addr_err = 0. pc8_d follows pc_d.
- Each clock edge with stall = 0:
  - ir_d ← im_rdata
  - pc_d ← pc_f
  - pc_f ← npc
- Each clock edge with stall = 1:
  - pc_f, ir_d and pc_d hold.
  - addr_err ← 0.
  - No redirect is taken. The branch in ID is unresolved and is re-evaluated on the first non-stall cycle.
- Next-PC (combinational), fields taken from ir_d:
  - none, or branch not taken: pc_f + 4
  - beq taken (co = 1) / bne taken (co = 0): pc_d + 4 + (sext(ir_d[15:0]) << 2), 32-bit wrap.
  - j / jal: {pc_d_plus4[31:28], ir_d[25:0], 2'b00}
  - jr: {rs_fwd[31:2], 2'b00}. addr_err ← (rs_fwd[1:0] != 0), registered, only on a non-stall edge.
- Delay slot: the instruction fetched while the branch is in ID always enters ID next cycle. There is no flush.
- Redirect latency: the branch is in ID in cycle N. The target appears on pc_f in cycle N+1, the same cycle the delay slot moves to ID.
- Back-to-back control transfers are not flushed: a branch sitting in a delay slot redirects normally.
- im_addr wraps modulo 2^IM_AW words. A PC below RESET_PC wraps silently. No error is raised.
- Simultaneous stall and taken branch: stall wins; the redirect is re-evaluated after release.
- Reset during a stall or during a redirect: reset dominates and all state returns to reset values.

Decomposition:
- Shared package:
  - br_type encodings (BR_NONE … BR_JR)
  - RESET_PC default
  - NOP = 32'h0
- Sub-module npc: purely combinational next-PC mux. Inputs pc_f, pc_d, ir_d, br_type, co, rs_fwd; outputs npc and misalign.
- Top level holds the PC and IF/ID registers.

Test Plan:
- Reset and straight-line fetch:
  - Assert reset mid-cycle → pc_f = 0x3000 immediately and ir_d = 0.
  - Release, 3 clocks, br_type = 0 → pc_f sequence 0x3004, 0x3008, 0x300C; im_addr = 3.
- beq taken:
  - pc_d = 0x3010, ir_d imm = 0x0004, co = 1 → next pc_f = 0x3024.
  - The delay slot from 0x3014 appears in pc_d the same cycle.
  - Repeat with co = 0 → pc_f = 0x3018.
- bne backward:
  - pc_d = 0x3020, imm = 0xFFFE, co = 0 → pc_f = 0x301C.
- jal and jr:
  - jal with pc_d = 0x3000, index = 0x0000C10 → pc_f = 0x3040, pc8_d = 0x3008.
  - jr with rs_fwd = 0x3102 → pc_f = 0x3100, addr_err = 1 for exactly one cycle.
- Stall over a taken branch:
  - stall = 1 for 2 cycles while beq is in ID with co = 0 → pc_f, ir_d and pc_d unchanged.
  - co goes to 1 at release → redirect to target on the release edge.
- im_addr wrap:
  - pc_f = 0x3FFC → im_addr = 1023.
  - Next sequential → pc_f = 0x4000, im_addr = 0.
